// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer slice.
//   state_t : sequencer FSM states
//   cmd_t   : one command-table record (colour, centre x/y, radius)
//   COLOUR_*: 3-bit RGB colour constants
//   isBusyState(): true for every state that is actively working
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FETCH,
        ST_LATCH,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] colour;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] radius;
    } cmd_t;

    localparam logic [2:0] COLOUR_BLACK   = 3'b000;
    localparam logic [2:0] COLOUR_BLUE    = 3'b001;
    localparam logic [2:0] COLOUR_GREEN   = 3'b010;
    localparam logic [2:0] COLOUR_CYAN    = 3'b011;
    localparam logic [2:0] COLOUR_RED     = 3'b100;
    localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOUR_WHITE   = 3'b111;

    // IDLE and DONE are the only resting states; everything else counts as busy.
    function automatic logic isBusyState(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/pixel_mux.sv
// Selects which engine owns the VGA pixel stream.
//   state_i          : current sequencer state
//   fill*_i          : pixel outputs of the fill engine
//   circ*_i          : pixel outputs of the circle engine
//   vga*_o           : muxed pixel stream (all zero when no engine is running)
module pixel_mux
    import draw_pkg::*;
(
    input  state_t     state_i,
    input  logic [7:0] fillX_i,
    input  logic [6:0] fillY_i,
    input  logic [2:0] fillCol_i,
    input  logic       fillPlot_i,
    input  logic [7:0] circX_i,
    input  logic [6:0] circY_i,
    input  logic [2:0] circCol_i,
    input  logic       circPlot_i,
    output logic [7:0] vgaX_o,
    output logic [6:0] vgaY_o,
    output logic [2:0] vgaColour_o,
    output logic       vgaPlot_o
);

    // Only the engine that is currently started may drive the screen, so a
    // stray plot from an idle engine can never reach the frame buffer.
    always_comb begin
        vgaX_o      = '0;
        vgaY_o      = '0;
        vgaColour_o = '0;
        vgaPlot_o   = 1'b0;
        if (state_i == ST_FILL) begin
            vgaX_o      = fillX_i;
            vgaY_o      = fillY_i;
            vgaColour_o = fillCol_i;
            vgaPlot_o   = fillPlot_i;
        end else if (state_i == ST_DRAW) begin
            vgaX_o      = circX_i;
            vgaY_o      = circY_i;
            vgaColour_o = circCol_i;
            vgaPlot_o   = circPlot_i;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Walks a command table and hands each circle to the circle engine, optionally
// clearing the screen first with the fill engine.
//   clk, rst            : clock and synchronous active-high reset
//   start, loop_en,
//   clear_en            : run request, wrap-around enable, initial clear enable
//   cmd_idx, cmd_*      : command-table read address and returned record
//   fill_start/done     : fill-engine handshake
//   circ_start/done     : circle-engine handshake
//   eng_*               : parameters presented to the engines
//   fill_*/circ_* pixel : engine pixel outputs, muxed onto vga_*
//   busy, done,
//   shapes_drawn        : status
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int         NUM_CMDS     = 16,
    parameter int         IDX_W        = $clog2(NUM_CMDS),
    parameter logic [2:0] CLEAR_COLOUR = COLOUR_BLACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             loop_en,
    input  logic             clear_en,
    output logic [IDX_W-1:0] cmd_idx,
    input  logic [2:0]       cmd_colour,
    input  logic [7:0]       cmd_cx,
    input  logic [6:0]       cmd_cy,
    input  logic [7:0]       cmd_radius,
    output logic             fill_start,
    input  logic             fill_done,
    output logic             circ_start,
    input  logic             circ_done,
    output logic [2:0]       eng_colour,
    output logic [7:0]       eng_cx,
    output logic [6:0]       eng_cy,
    output logic [7:0]       eng_radius,
    input  logic [7:0]       fill_x,
    input  logic [6:0]       fill_y,
    input  logic [2:0]       fill_col,
    input  logic             fill_plot,
    input  logic [7:0]       circ_x,
    input  logic [6:0]       circ_y,
    input  logic [2:0]       circ_col,
    input  logic             circ_plot,
    output logic [7:0]       vga_x,
    output logic [6:0]       vga_y,
    output logic [2:0]       vga_colour,
    output logic             vga_plot,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   shapes_drawn
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CMDS - 1);
    localparam logic [IDX_W:0]   MAX_SHAPES = (IDX_W + 1)'(NUM_CMDS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cmdIdx_q, cmdIdx_d;
    logic [IDX_W:0]   shapes_q, shapes_d;
    cmd_t             eng_q, eng_d;
    logic             abort_q, abort_d;
    logic             fillStart_q, circStart_q, busy_q, done_q;

    // Next-state logic. An engine that has been started is always allowed to
    // finish: dropping start in FILL or DRAW only records an abort, which is
    // honoured once that engine reports done. Done pulses from the other
    // engine are never looked at in these states.
    always_comb begin
        state_d  = state_q;
        cmdIdx_d = cmdIdx_q;
        shapes_d = shapes_q;
        eng_d    = eng_q;
        abort_d  = abort_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmdIdx_d = '0;
                    shapes_d = '0;
                    abort_d  = 1'b0;
                    if (clear_en) begin
                        eng_d.colour = CLEAR_COLOUR;
                        state_d      = ST_FILL;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FILL: begin
                if (!start) abort_d = 1'b1;
                if (fill_done) state_d = (abort_q || !start) ? ST_IDLE : ST_FETCH;
            end
            ST_FETCH: begin
                state_d = start ? ST_LATCH : ST_IDLE;
            end
            ST_LATCH: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    eng_d.colour = cmd_colour;
                    eng_d.cx     = cmd_cx;
                    eng_d.cy     = cmd_cy;
                    eng_d.radius = cmd_radius;
                    // A zero radius marks an empty slot: skip it without drawing.
                    state_d = (cmd_radius == 8'd0) ? ST_NEXT : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (!start) abort_d = 1'b1;
                if (circ_done) begin
                    if (shapes_q < MAX_SHAPES) shapes_d = shapes_q + 1'b1;
                    state_d = (abort_q || !start) ? ST_IDLE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (cmdIdx_q < LAST_IDX) begin
                    cmdIdx_d = cmdIdx_q + 1'b1;
                    state_d  = ST_FETCH;
                end else if (loop_en) begin
                    cmdIdx_d = '0;
                    shapes_d = '0;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers. Handshake and status outputs are decoded
    // from the next state so they change on the same edge as the state itself;
    // fill_start and circ_start come from distinct states and so can never
    // overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmdIdx_q    <= '0;
            shapes_q    <= '0;
            eng_q       <= '0;
            abort_q     <= 1'b0;
            fillStart_q <= 1'b0;
            circStart_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmdIdx_q    <= cmdIdx_d;
            shapes_q    <= shapes_d;
            eng_q       <= eng_d;
            abort_q     <= abort_d;
            fillStart_q <= (state_d == ST_FILL);
            circStart_q <= (state_d == ST_DRAW);
            busy_q      <= isBusyState(state_d);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign cmd_idx      = cmdIdx_q;
    assign shapes_drawn = shapes_q;
    assign eng_colour   = eng_q.colour;
    assign eng_cx       = eng_q.cx;
    assign eng_cy       = eng_q.cy;
    assign eng_radius   = eng_q.radius;
    assign fill_start   = fillStart_q;
    assign circ_start   = circStart_q;
    assign busy         = busy_q;
    assign done         = done_q;

    pixel_mux u_pixel_mux (
        .state_i     (state_q),
        .fillX_i     (fill_x),
        .fillY_i     (fill_y),
        .fillCol_i   (fill_col),
        .fillPlot_i  (fill_plot),
        .circX_i     (circ_x),
        .circY_i     (circ_y),
        .circCol_i   (circ_col),
        .circPlot_i  (circ_plot),
        .vgaX_o      (vga_x),
        .vgaY_o      (vga_y),
        .vgaColour_o (vga_colour),
        .vgaPlot_o   (vga_plot)
    );

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 16, meaning number of command-table entries (2..256).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_CMDS), meaning width of the command index.
REQ-003 SHALL have parameter CLEAR_COLOUR, default 3'b000, meaning the colour used by the initial screen fill.
REQ-004 SHALL have the following ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  level request to run the sequence.
- loop_en  in  1  when 1, wrap to entry 0 after the last entry instead of finishing.
- clear_en  in  1  when 1, fill the screen before the first entry.
- cmd_idx  out  IDX_W  command-table read address.
- cmd_colour  in  3  colour field, valid one cycle after cmd_idx changes.
- cmd_cx  in  8  centre x field, same timing as cmd_colour.
- cmd_cy  in  7  centre y field, same timing as cmd_colour.
- cmd_radius  in  8  radius field, same timing as cmd_colour.
- fill_start  out  1  fill-engine start.
- fill_done  in  1  fill-engine done.
- circ_start  out  1  circle-engine start.
- circ_done  in  1  circle-engine done.
- eng_colour  out  3  colour presented to both engines.
- eng_cx  out  8  centre x presented to the circle engine.
- eng_cy  out  7  centre y presented to the circle engine.
- eng_radius  out  8  radius presented to the circle engine.
- fill_x, fill_y, fill_col, fill_plot  in  8/7/3/1  fill-engine pixel outputs.
- circ_x, circ_y, circ_col, circ_plot  in  8/7/3/1  circle-engine pixel outputs.
- vga_x, vga_y, vga_colour, vga_plot  out  8/7/3/1  muxed pixel stream.
- busy  out  1  high whenever the FSM is outside IDLE and DONE.
- done  out  1  high in DONE.
- shapes_drawn  out  IDX_W+1  count of circles completed in the current pass.

Function
REQ-005 SHALL implement the states IDLE, FILL, FETCH, LATCH, DRAW, NEXT and DONE.
REQ-006 In IDLE with start=1, SHALL go to FILL if clear_en=1, else to FETCH; cmd_idx=0 and shapes_drawn=0 on entry.
REQ-007 In FILL, SHALL assert fill_start with eng_colour=CLEAR_COLOUR, and go to FETCH on fill_done.
REQ-008 FETCH SHALL last exactly one cycle (table read latency); LATCH SHALL register the cmd_* fields into eng_* in one cycle.
REQ-009 In LATCH, if cmd_radius==0 the entry SHALL be skipped: go directly to NEXT, with no circ_start and no increment of shapes_drawn.
REQ-010 In DRAW, SHALL hold circ_start high until circ_done; eng_* SHALL remain stable throughout DRAW.
REQ-011 On circ_done in DRAW, SHALL increment shapes_drawn (saturating at NUM_CMDS) and go to NEXT.
REQ-012 NEXT, when cmd_idx<NUM_CMDS-1, SHALL increment cmd_idx and go to FETCH.
REQ-013 NEXT, at the last entry with loop_en=1, SHALL set cmd_idx=0, clear shapes_drawn and go to FETCH; there is no re-fill.
REQ-014 NEXT, at the last entry with loop_en=0, SHALL go to DONE.
REQ-015 If start deasserts in FILL or DRAW, the FSM SHALL wait for the current engine's done and then go to IDLE; in FETCH, LATCH or NEXT it SHALL go to IDLE immediately.
REQ-016 DONE SHALL hold until start=0, then go to IDLE.
REQ-017 fill_start and circ_start SHALL never be high in the same cycle.
REQ-018 vga_* SHALL select the fill_* inputs in FILL, the circ_* inputs in DRAW, and be zero otherwise; vga_plot SHALL be 0 outside FILL and DRAW.
REQ-019 cmd_idx arithmetic SHALL be IDX_W-bit and SHALL never exceed NUM_CMDS-1, including for non-power-of-two NUM_CMDS.
REQ-020 A done pulse from the engine not currently started SHALL be ignored.

Reset
REQ-021 On rst=1 at a clk edge, SHALL enter IDLE and clear cmd_idx, shapes_drawn, eng_*, fill_start, circ_start, busy, done and vga_plot to 0.
REQ-022 Reset asserted mid-DRAW or mid-FILL SHALL take effect on the next edge, regardless of engine state.

Structure
REQ-023 The state enum, the command-record struct (colour, cx, cy, radius) and the colour constants SHALL live in the shared package draw_pkg.
REQ-024 The pixel mux SHALL be a sub-module named pixel_mux; the FSM and counters SHALL stay in draw_sequencer.

Verification
REQ-025 NUM_CMDS=4, clear_en=1, loop_en=0, fill_done after 10 cycles, circ_done after 5 -> exactly 1 fill_start episode and 4 circ_start episodes, then done=1 and shapes_drawn=4.
REQ-026 Entry 2 with radius=0 -> circ_start never high while eng_* hold entry 2's values, and shapes_drawn=3 at DONE.
REQ-027 loop_en=1, NUM_CMDS=3 -> cmd_idx sequence 0,1,2,0,1; fill_start asserted only before the first 0.
REQ-028 start dropped mid-DRAW of entry 1 -> circ_start held until circ_done, then IDLE with busy=0.
REQ-029 rst pulsed during FILL -> the next cycle is IDLE with all outputs 0, and fill_start=0.
REQ-030 NUM_CMDS=5 (non-power-of-two) -> cmd_idx never reaches 5, and a stray fill_done during DRAW is ignored.
